// File: rtl/trig_pulse_scheduler.sv
// trig_pulse_scheduler
//   Turns timestamped trigger messages into output pulses at a programmable
//   per-channel delay. Each channel has a FIFO of due times. The FIFO head is
//   compared against local time every cycle: it either fires a pulse, is
//   dropped as late, or is held until its due time.
//
// Ports
//   clk_sys_i, rst_sys_i    : sole clock; synchronous active-high reset
//   tm_cycles_i, tm_valid_i : free-running local time and its lock/valid flag
//   trig_valid_i/ready_o    : trigger message handshake (ready is always 1)
//   trig_ch_i, trig_ts_i    : target channel and source timestamp
//   cfg_enable_i            : per-channel enable (clearing it flushes the queue)
//   cfg_delay_i             : per-channel delay, channel 0 in the LSBs
//   pulse_o                 : registered output pulses, g_pulse_width cycles long
//   cnt_fired_o / cnt_missed_o / cnt_ovf_o : 16-bit saturating statistics
//
// Build option
//   TRIG_PULSE_SCHED_STATS_EN : when defined, the statistics counters are
//   implemented. When undefined, the counter outputs are tied to 0.
module trig_pulse_scheduler #(
    parameter int g_num_channels = 4,
    parameter int g_fifo_depth   = 16,
    parameter int g_coarse_bits  = 28,
    parameter int g_pulse_width  = 6,
    localparam int c_ch_w = (g_num_channels > 1) ? $clog2(g_num_channels) : 1
) (
    input  logic                                    clk_sys_i,
    input  logic                                    rst_sys_i,
    input  logic [g_coarse_bits-1:0]                tm_cycles_i,
    input  logic                                    tm_valid_i,
    input  logic                                    trig_valid_i,
    output logic                                    trig_ready_o,
    input  logic [c_ch_w-1:0]                       trig_ch_i,
    input  logic [g_coarse_bits-1:0]                trig_ts_i,
    input  logic [g_num_channels-1:0]               cfg_enable_i,
    input  logic [g_num_channels*g_coarse_bits-1:0] cfg_delay_i,
    output logic [g_num_channels-1:0]               pulse_o,
    output logic [g_num_channels*16-1:0]            cnt_fired_o,
    output logic [g_num_channels*16-1:0]            cnt_missed_o,
    output logic [15:0]                             cnt_ovf_o
);

    localparam int c_aw   = $clog2(g_fifo_depth);
    localparam int c_pw_w = $clog2(g_pulse_width + 1);
    localparam logic [g_coarse_bits-1:0] c_half      = {1'b1, {(g_coarse_bits-1){1'b0}}};
    localparam logic [g_coarse_bits-1:0] c_min_slack = g_coarse_bits'(3);
    localparam logic [c_pw_w-1:0]        c_pw_load   = c_pw_w'(g_pulse_width);
    localparam logic [c_pw_w-1:0]        c_pw_one    = c_pw_w'(1);
    localparam logic [c_aw:0]            c_ptr_one   = (c_aw+1)'(1);
    localparam logic [c_ch_w:0]          c_nch       = (c_ch_w+1)'(g_num_channels);

    typedef enum logic {S_IDLE, S_HIGH} state_t;

    logic w_in_range;

    assign trig_ready_o = 1'b1;
    assign w_in_range   = {1'b0, trig_ch_i} < c_nch;

`ifdef TRIG_PULSE_SCHED_STATS_EN
    logic [g_num_channels-1:0] w_ovf_ch;
    logic [15:0]               r_cnt_ovf;

    function automatic logic [15:0] f_sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) r_cnt_ovf <= '0;
        else           r_cnt_ovf <= f_sat_add(r_cnt_ovf,
                                      {1'b0, (trig_valid_i && !w_in_range) || (|w_ovf_ch)});
    end
    assign cnt_ovf_o = r_cnt_ovf;
`else
    assign cnt_ovf_o = '0;
`endif

    for (genvar c = 0; c < g_num_channels; c++) begin : g_ch
        localparam logic [c_ch_w-1:0] c_idx = c_ch_w'(c);

        logic [g_coarse_bits-1:0] r_mem [g_fifo_depth];
        logic [c_aw:0]            r_wr, r_rd;
        logic [g_coarse_bits-1:0] w_due, w_slack, w_head, w_age;
        logic w_sel, w_empty, w_full, w_early, w_push, w_eval, w_pop, w_fire;
        state_t                   r_state, w_state_nxt;
        logic [c_pw_w-1:0]        r_wcnt, w_wcnt_nxt;

        assign w_sel   = trig_valid_i && w_in_range && (trig_ch_i == c_idx) && cfg_enable_i[c];
        assign w_due   = trig_ts_i + cfg_delay_i[c*g_coarse_bits +: g_coarse_bits];
        // Entries land at the head one cycle after the push, so anything due
        // less than 3 cycles out could fire early or against a stale compare.
        // Such entries are treated as missed at the door.
        assign w_slack = w_due - tm_cycles_i;
        assign w_early = tm_valid_i && (w_slack < c_min_slack);
        // Occupancy is taken at cycle start: a same-cycle pop does not make room.
        assign w_empty = (r_wr == r_rd);
        assign w_full  = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
        assign w_push  = w_sel && !w_full && !w_early;

        // Age of the head relative to now; the lower half of the circle is
        // "already passed", the upper half is "still in the future".
        assign w_head  = r_mem[r_rd[c_aw-1:0]];
        assign w_age   = tm_cycles_i - w_head;
        assign w_eval  = tm_valid_i && cfg_enable_i[c] && !w_empty;
        assign w_fire  = w_eval && (w_age == '0);
        assign w_pop   = w_eval && (w_age < c_half);

        always_ff @(posedge clk_sys_i) begin
            if (w_push) r_mem[r_wr[c_aw-1:0]] <= w_due;
        end

        always_ff @(posedge clk_sys_i) begin
            if (rst_sys_i) begin
                r_wr <= '0;
                r_rd <= '0;
            end else if (!cfg_enable_i[c]) begin
                r_rd <= r_wr;   // flush
            end else begin
                if (w_push) r_wr <= r_wr + c_ptr_one;
                if (w_pop)  r_rd <= r_rd + c_ptr_one;
            end
        end

        always_ff @(posedge clk_sys_i) begin
            if (rst_sys_i) begin
                r_state <= S_IDLE;
                r_wcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_wcnt  <= w_wcnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_wcnt_nxt  = r_wcnt;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        w_state_nxt = S_HIGH;
                        w_wcnt_nxt  = c_pw_load;
                    end
                end
                S_HIGH: begin
                    if (w_fire) begin
                        w_wcnt_nxt = c_pw_load;  // retrigger extends the pulse
                    end else if (r_wcnt == c_pw_one) begin
                        w_state_nxt = S_IDLE;
                        w_wcnt_nxt  = '0;
                    end else begin
                        w_wcnt_nxt = r_wcnt - c_pw_one;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        assign pulse_o[c] = (r_state == S_HIGH);

`ifdef TRIG_PULSE_SCHED_STATS_EN
        logic [15:0] r_fired, r_missed;
        logic        w_late, w_early_miss;

        assign w_late       = w_pop && !w_fire;
        assign w_early_miss = w_sel && !w_full && w_early;
        assign w_ovf_ch[c]  = w_sel && w_full;

        always_ff @(posedge clk_sys_i) begin
            if (rst_sys_i) begin
                r_fired  <= '0;
                r_missed <= '0;
            end else begin
                r_fired  <= f_sat_add(r_fired, {1'b0, w_fire});
                r_missed <= f_sat_add(r_missed, {1'b0, w_late} + {1'b0, w_early_miss});
            end
        end
        assign cnt_fired_o[c*16 +: 16]  = r_fired;
        assign cnt_missed_o[c*16 +: 16] = r_missed;
`else
        assign cnt_fired_o[c*16 +: 16]  = '0;
        assign cnt_missed_o[c*16 +: 16] = '0;
`endif
    end

endmodule

// File: tb/tb_trig_pulse_scheduler.sv
module tb_trig_pulse_scheduler;
    localparam int N  = 4;
    localparam int TW = 28;
    localparam int PW = 6;
`ifdef TRIG_PULSE_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [TW-1:0]   tm = '0;
    logic            tm_valid = 1'b1;
    logic            trig_valid = 1'b0;
    logic            trig_ready;
    logic [1:0]      trig_ch = '0;
    logic [TW-1:0]   trig_ts = '0;
    logic [N-1:0]    cfg_en = '1;
    logic [N*TW-1:0] cfg_delay = '0;
    logic [N-1:0]    pulse;
    logic [N*16-1:0] cnt_fired, cnt_missed;
    logic [15:0]     cnt_ovf;

    trig_pulse_scheduler dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .tm_cycles_i(tm), .tm_valid_i(tm_valid),
        .trig_valid_i(trig_valid), .trig_ready_o(trig_ready), .trig_ch_i(trig_ch),
        .trig_ts_i(trig_ts), .cfg_enable_i(cfg_en), .cfg_delay_i(cfg_delay),
        .pulse_o(pulse), .cnt_fired_o(cnt_fired), .cnt_missed_o(cnt_missed),
        .cnt_ovf_o(cnt_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ex(input int v);
        return STATS ? v : 0;
    endfunction

    // Scoreboard of expected pulses: rising tm and length per channel.
    typedef struct {
        int            ch;
        logic [TW-1:0] rise;
        int            len;
    } pexp_t;
    pexp_t sb[$];

    task automatic expect_pulse(input int ch, input logic [TW-1:0] rise, input int len);
        pexp_t p;
        p.ch = ch; p.rise = rise; p.len = len;
        sb.push_back(p);
    endtask

    logic [TW-1:0] m_rise [N];
    int            m_len  [N];
    bit            m_in   [N];

    task automatic check_pulse(input int c);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].ch == c) idx = i;
        if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse ch%0d: rise tm %0d len %0d, expected none",
                     c, m_rise[c], m_len[c]);
        end else begin
            chk($sformatf("pulse_rise_ch%0d", c), 32'(m_rise[c]), 32'(sb[idx].rise));
            chk($sformatf("pulse_len_ch%0d", c), m_len[c], sb[idx].len);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_in[c] = 1'b0;
            end else if (pulse[c]) begin
                if (!m_in[c]) begin
                    m_in[c] = 1'b1; m_rise[c] = tm; m_len[c] = 1;
                end else m_len[c]++;
            end else if (m_in[c]) begin
                m_in[c] = 1'b0;
                check_pulse(c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tm = tm + 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_en = '1;
        cfg_delay = '0;
        tm_valid = 1'b1;
        chk({tag, "_rst_pulse"}, 32'(pulse), 0);
        chk({tag, "_rst_fired"}, 32'(|cnt_fired), 0);
        chk({tag, "_rst_missed"}, 32'(|cnt_missed), 0);
        chk({tag, "_rst_ovf"}, 32'(cnt_ovf), 0);
    endtask

    task automatic push(input int ch, input logic [TW-1:0] ts);
        trig_valid = 1'b1;
        trig_ch = 2'(ch);
        trig_ts = ts;
        step();
        trig_valid = 1'b0;
    endtask

    function automatic int fired(input int ch);
        return int'(cnt_fired[ch*16 +: 16]);
    endfunction
    function automatic int missed(input int ch);
        return int'(cnt_missed[ch*16 +: 16]);
    endfunction

    typedef struct {
        int            ch;
        bit            en;
        logic [TW-1:0] delay;
        logic [TW-1:0] tm0;
        logic [TW-1:0] ts;
        bit            pulse;
        int            run;
        int            fired;
        int            missed;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [TW-1:0] due;
        vecs[0] = '{ch:0, en:1, delay:28'd2000, tm0:28'd1000, ts:28'd1000, pulse:1, run:2020, fired:1, missed:0};
        vecs[1] = '{ch:1, en:1, delay:28'd2,    tm0:28'd500,  ts:28'd500,  pulse:0, run:1,    fired:0, missed:1};
        vecs[2] = '{ch:3, en:1, delay:28'd10,   tm0:28'hFFFFFFB, ts:28'hFFFFFFB, pulse:1, run:25, fired:1, missed:0};
        vecs[3] = '{ch:0, en:1, delay:28'd3,    tm0:28'd100,  ts:28'd100,  pulse:1, run:15,   fired:1, missed:0};
        vecs[4] = '{ch:2, en:1, delay:28'd1,    tm0:28'd200,  ts:28'd200,  pulse:0, run:3,    fired:0, missed:1};
        vecs[5] = '{ch:1, en:0, delay:28'd50,   tm0:28'd600,  ts:28'd600,  pulse:0, run:60,   fired:0, missed:0};
        vecs[6] = '{ch:2, en:1, delay:28'd20,   tm0:28'd400,  ts:28'd370,  pulse:0, run:2,    fired:0, missed:1};
        vecs[7] = '{ch:3, en:1, delay:28'd0,    tm0:28'd300,  ts:28'd305,  pulse:1, run:15,   fired:1, missed:0};

        rst = 1'b1;
        run(2);
        do_reset("init");
        chk("trig_ready", 32'(trig_ready), 1);

        // Single-message vectors.
        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            do_reset($sformatf("v%0d", k));
            cfg_delay[v.ch*TW +: TW] = v.delay;
            if (!v.en) cfg_en[v.ch] = 1'b0;
            tm = v.tm0;
            if (v.pulse) begin
                due = v.ts + v.delay;
                expect_pulse(v.ch, due + 1'b1, PW);
            end
            push(v.ch, v.ts);
            run(v.run);
            chk($sformatf("v%0d_fired", k), fired(v.ch), ex(v.fired));
            chk($sformatf("v%0d_missed", k), missed(v.ch), ex(v.missed));
            chk($sformatf("v%0d_ovf", k), 32'(cnt_ovf), 0);
            chk($sformatf("v%0d_pending", k), sb.size(), 0);
        end

        // Queue overflow: 17 back-to-back pushes, 16 fire one cycle apart.
        do_reset("ovf");
        cfg_delay[2*TW +: TW] = 28'd100;
        tm = 28'd2000;
        expect_pulse(2, 28'd2101, 15 + PW);
        for (int i = 0; i < 17; i++) push(2, tm);
        chk("ovf_cnt", 32'(cnt_ovf), ex(1));
        run(130);
        chk("ovf_fired", fired(2), ex(16));
        chk("ovf_missed", missed(2), 0);
        chk("ovf_pending", sb.size(), 0);

        // Retrigger: due times 3 apart merge into one 9-cycle pulse.
        do_reset("retrig");
        cfg_delay[0 +: TW] = 28'd10;
        tm = 28'd5000;
        expect_pulse(0, 28'd5011, 3 + PW);
        push(0, 28'd5000);
        push(0, 28'd5003);
        run(30);
        chk("retrig_fired", fired(0), ex(2));
        chk("retrig_pending", sb.size(), 0);

        // Delay change affects only later entries.
        do_reset("dly");
        cfg_delay[TW +: TW] = 28'd10;
        tm = 28'd6000;
        expect_pulse(1, 28'd6011, PW);
        expect_pulse(1, 28'd6032, PW);
        push(1, 28'd6000);
        cfg_delay[TW +: TW] = 28'd30;
        push(1, tm);
        run(50);
        chk("dly_fired", fired(1), ex(2));
        chk("dly_pending", sb.size(), 0);

        // Time invalid past all due times: all five are missed afterwards.
        do_reset("tmv");
        cfg_delay[TW +: TW] = 28'd20;
        tm = 28'd7000;
        for (int i = 0; i < 5; i++) push(1, tm);
        tm_valid = 1'b0;
        run(40);
        chk("tmv_hold_missed", missed(1), 0);
        tm_valid = 1'b1;
        run(10);
        chk("tmv_missed", missed(1), ex(5));
        chk("tmv_fired", fired(1), 0);
        due = tm + 28'd20;
        expect_pulse(1, due + 1'b1, PW);
        push(1, tm);
        run(30);
        chk("tmv_after_fired", fired(1), ex(1));
        chk("tmv_pending", sb.size(), 0);

        // Disabling a channel flushes its queue.
        do_reset("flush");
        cfg_delay[3*TW +: TW] = 28'd50;
        tm = 28'd8000;
        push(3, 28'd8000);
        cfg_en[3] = 1'b0;
        step();
        cfg_en[3] = 1'b1;
        run(70);
        chk("flush_fired", fired(3), 0);
        chk("flush_missed", missed(3), 0);

        // Reset mid-pulse terminates the pulse at that edge.
        do_reset("midrst");
        cfg_delay[0 +: TW] = 28'd5;
        tm = 28'd9000;
        push(0, 28'd9000);
        run(5);
        chk("midrst_pulse_hi", 32'(pulse[0]), 1);
        chk("midrst_fired_pre", fired(0), ex(1));
        rst = 1'b1;
        step();
        chk("midrst_pulse_lo", 32'(pulse[0]), 0);
        chk("midrst_fired_clr", fired(0), 0);
        rst = 1'b0;
        step();
        chk("midrst_pulse_lo2", 32'(pulse[0]), 0);
        run(10);
        chk("final_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_pulse_scheduler.md
TRIG_PULSE_SCHEDULER -- requirements
Module: trig_pulse_scheduler

Interface
REQ-001 SHALL have parameter g_num_channels, default 4: number of output channels, 1..8.
REQ-002 SHALL have parameter g_fifo_depth, default 16: entries per channel queue, power of 2, 2..64.
REQ-003 SHALL have parameter g_coarse_bits, default 28: timestamp width in clk_sys cycles.
REQ-004 SHALL have parameter g_pulse_width, default 6: output pulse length in cycles, >=1.
REQ-005 SHALL have ports (clock and reset first):
- clk_sys_i  in  1  system clock; sole clock.
- rst_sys_i  in  1  reset, synchronous, active-high.
- tm_cycles_i  in  g_coarse_bits  local time; +1 per cycle, wraps.
- tm_valid_i  in  1  local time is locked and valid.
- trig_valid_i  in  1  trigger message present.
- trig_ready_o  out  1  message accepted when high with trig_valid_i.
- trig_ch_i  in  clog2(g_num_channels)  target channel.
- trig_ts_i  in  g_coarse_bits  source timestamp.
- cfg_enable_i  in  g_num_channels  per-channel enable.
- cfg_delay_i  in  g_num_channels*g_coarse_bits  per-channel delay, channel 0 in LSBs.
- pulse_o  out  g_num_channels  output pulses.
- cnt_fired_o  out  g_num_channels*16  pulses fired per channel.
- cnt_missed_o  out  g_num_channels*16  entries dropped late per channel.
- cnt_ovf_o  out  16  messages dropped on a full queue or out-of-range channel.

Function
REQ-006 SHALL set trig_ready_o = 1 always; a handshake occurs when trig_valid_i = 1.
REQ-007 On handshake with an enabled channel whose queue is not full, SHALL push due = (trig_ts_i + delay[ch]) mod 2^g_coarse_bits.
- Queue full or trig_ch_i >= g_num_channels: SHALL drop and increment cnt_ovf_o.
- Channel disabled: SHALL drop silently.
REQ-008 Full/push SHALL use the occupancy at cycle start; a pop in the same cycle SHALL NOT make room.
REQ-009 A pushed entry SHALL become the visible head no earlier than the cycle after the push.
REQ-010 Each cycle with tm_valid_i = 1, each non-empty channel SHALL evaluate its head:
- head == tm_cycles_i: pop, fire.
- (tm_cycles_i - head) mod 2^g_coarse_bits in [1, 2^(g_coarse_bits-1)): pop, increment cnt_missed_o[ch], no pulse.
- Otherwise: hold.
REQ-011 At most one pop per channel per cycle.
REQ-012 With tm_valid_i = 0, SHALL perform no evaluation, pop or miss; queues hold. Stale heads are evaluated under REQ-010 once tm_valid_i returns.
REQ-013 Per-channel pulse FSM:
- States: IDLE, HIGH.
- IDLE -> HIGH on fire; load width counter with g_pulse_width.
- HIGH: decrement each cycle; -> IDLE when the counter reaches 1.
- A fire while in HIGH SHALL reload the counter (retrigger, pulse extended).
REQ-014 pulse_o[ch] SHALL be registered and high exactly in the g_pulse_width cycles after the match cycle. Latency from match to rising edge: 1 cycle.
REQ-015 Minimum usable delay SHALL be 3 cycles. Smaller effective delays are counted as missed, never fired.
REQ-016 Due-time arithmetic SHALL wrap modulo 2^g_coarse_bits. Entries straddling the tm wrap SHALL fire correctly.
REQ-017 Counters SHALL be 16-bit saturating, with no wrap.
REQ-018 Clearing cfg_enable_i[ch] SHALL flush that queue on the next cycle. An active pulse completes normally.
REQ-019 cfg_delay_i changes SHALL affect only subsequently pushed entries.

Reset
REQ-020 While rst_sys_i = 1 at a clock edge, SHALL empty all queues, set pulse FSMs to IDLE, and clear all counters.
REQ-021 After that edge, SHALL hold pulse_o = 0 and all counters = 0. trig_ready_o stays 1.
REQ-022 Reset asserted mid-pulse SHALL terminate the pulse at that edge. Queued entries are lost without counting.

Configuration
REQ-023 Macro TRIG_PULSE_SCHED_STATS_EN:
- Defined: cnt_fired_o, cnt_missed_o and cnt_ovf_o are implemented as in REQ-007, REQ-010 and REQ-017.
- Undefined: no counter registers; those outputs SHALL be constant 0; all other behaviour is identical.

Verification
REQ-024 Bench SHALL cover:
- Defaults, ch0 delay 2000, tm valid; push ts=1000 -> pulse_o[0] high tm 3001..3006; cnt_fired[0]=1.
- ch1 delay 2; push ts=tm -> no pulse; cnt_missed[1]=1 within 2 cycles of the push.
- ch2 delay 100; 17 pushes in 17 consecutive cycles -> 16 queued, cnt_ovf=1; 16 pulses fire in order with retriggers merged.
- ch3 delay 10; ts=2^28-5 -> due 5 after wrap; pulse at tm 6..11.
- Two entries due 3 cycles apart on ch0 -> one continuous pulse of 9 cycles; cnt_fired[0]=2.
- Queue 5 entries, tm_valid_i=0 past all due times, then 1 -> cnt_missed=5, no pulses; rst_sys_i mid-pulse -> pulse_o=0 next cycle, counters 0.
